lsu_issue_buffer: RTL and testbench

- Small in-order buffer between the issue stage and the LSU.
- Accepts load/store fu_data from issue with a valid/ready handshake and forwards it to the LSU in program order.
- Produces the lsu_ready indication that the issue-side reorder logic consumes to decide whether to delay memory ops.
- Absorbs short LSU back-pressure so issue does not stall on every busy LSU cycle.

---
 rtl/ariane_pkg.sv | 28 ++
 rtl/lsu_issue_buffer.sv | 119 +++++++++++
 tb/tb_lsu_issue_buffer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Minimal issue-stage types shared by the LSU issue buffer and its neighbours.
package ariane_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR
  } fu_t;

  typedef logic [7:0] fu_op;

  typedef struct packed {
    fu_t                      fu;
    fu_op                     operation;
    logic [XLEN-1:0]          operand_a;
    logic [XLEN-1:0]          operand_b;
    logic [XLEN-1:0]          imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

endpackage

// File: rtl/lsu_issue_buffer.sv
// In-order issue->LSU buffer with zero-latency bypass when empty.
// Optional statistics ports (stall counter, occupancy high-water mark) are
// built when LSU_BUF_STATS_EN is defined.
module lsu_issue_buffer #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  lsu_valid_i,
  input  ariane_pkg::fu_data_t  fu_data_i,
  output logic                  lsu_ready_o,
  output logic                  lsu_valid_o,
  output ariane_pkg::fu_data_t  fu_data_o,
  input  logic                  lsu_ready_i,
`ifdef LSU_BUF_STATS_EN
  output logic [31:0]           stall_cnt_o,
  output logic [PTR_W:0]        hwm_o,
`endif
  output logic [PTR_W:0]        occupancy_o
);

  localparam int unsigned OCC_W = PTR_W + 1;

  ariane_pkg::fu_data_t mem_q [DEPTH];

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic empty;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_adv;

  // Handshake decode; ready depends on registered occupancy only
  always_comb begin
    empty       = (occ_q == '0);
    lsu_ready_o = (occ_q < OCC_W'(DEPTH));
    lsu_valid_o = ~flush_i & (~empty | lsu_valid_i);
    fu_data_o   = '0;
    if (lsu_valid_o) begin
      fu_data_o = empty ? fu_data_i : mem_q[rptr_q];
    end
    push   = lsu_valid_i & lsu_ready_o & ~flush_i;
    pop    = lsu_valid_o & lsu_ready_i;
    // a bypassed entry that the LSU takes immediately is never stored
    wr_en  = push & ~(empty & pop);
    rd_adv = pop & ~empty;
  end

  // Next pointer and occupancy values; flush wins over everything
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    occ_d  = occ_q;
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      occ_d  = '0;
    end else begin
      if (wr_en)  wptr_d = wptr_q + PTR_W'(1);
      if (rd_adv) rptr_d = rptr_q + PTR_W'(1);
      case ({wr_en, rd_adv})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      occ_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      occ_q  <= occ_d;
    end
  end

  // Entry storage, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= fu_data_i;
    end
  end

  assign occupancy_o = occ_q;

`ifdef LSU_BUF_STATS_EN
  logic [31:0]      stall_cnt_q;
  logic [OCC_W-1:0] hwm_q;

  // Issue-side stall counter and occupancy high-water mark; flush does not clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      hwm_q       <= '0;
    end else begin
      if (lsu_valid_i && !lsu_ready_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (occ_d > hwm_q) begin
        hwm_q <= occ_d;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign hwm_o       = hwm_q;
`endif

endmodule

// File: tb/tb_lsu_issue_buffer.sv
// Self-checking bench for lsu_issue_buffer against a queue-based reference.
module tb_lsu_issue_buffer;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           flush_i;
  logic           lsu_valid_i;
  fu_data_t       fu_data_i;
  logic           lsu_ready_o;
  logic           lsu_valid_o;
  fu_data_t       fu_data_o;
  logic           lsu_ready_i;
  logic [PTR_W:0] occupancy_o;
`ifdef LSU_BUF_STATS_EN
  logic [31:0]    stall_cnt_o;
  logic [PTR_W:0] hwm_o;
`endif

  lsu_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .lsu_valid_i (lsu_valid_i),
    .fu_data_i   (fu_data_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_valid_o (lsu_valid_o),
    .fu_data_o   (fu_data_o),
    .lsu_ready_i (lsu_ready_i),
`ifdef LSU_BUF_STATS_EN
    .stall_cnt_o (stall_cnt_o),
    .hwm_o       (hwm_o),
`endif
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: plain queue of buffered ops plus statistics counters
  fu_data_t    q[$];
  fu_data_t    in_log[$];
  fu_data_t    out_log[$];
  int          checks   = 0;
  int          failures = 0;
  logic        e_ready, e_valid;
  fu_data_t    e_data;
  logic        m_push, m_pop;
  int unsigned m_stall = 0;
  int unsigned m_hwm   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic fu_data_t mk(input int id);
    fu_data_t d;
    d.fu        = ($urandom_range(0, 1) == 0) ? LOAD : STORE;
    d.operation = 8'($urandom);
    d.operand_a = {$urandom, $urandom};
    d.operand_b = {$urandom, $urandom};
    d.imm       = {$urandom, $urandom};
    d.trans_id  = 3'(id);
    return d;
  endfunction

  // One clock cycle: drive at negedge, check before posedge, advance model after it
  task automatic cyc(input logic v, input fu_data_t d, input logic rdy, input logic fl,
                     input string tag);
    bit was_empty;
    lsu_valid_i = v;
    fu_data_i   = d;
    lsu_ready_i = rdy;
    flush_i     = fl;
    #2;
    was_empty = (q.size() == 0);
    e_ready   = (q.size() < DEPTH);
    e_valid   = !fl && (!was_empty || v);
    e_data    = '0;
    if (e_valid) e_data = was_empty ? d : q[0];
    chk({tag, ".ready"}, 256'(lsu_ready_o), 256'(e_ready));
    chk({tag, ".valid"}, 256'(lsu_valid_o), 256'(e_valid));
    chk({tag, ".data"},  256'(fu_data_o),   256'(e_data));
    chk({tag, ".occ"},   256'(occupancy_o), 256'(q.size()));
`ifdef LSU_BUF_STATS_EN
    chk({tag, ".stall"}, 256'(stall_cnt_o), 256'(m_stall));
    chk({tag, ".hwm"},   256'(hwm_o),       256'(m_hwm));
`endif
    m_push = v && e_ready && !fl;
    m_pop  = e_valid && rdy;
    if (lsu_valid_o && rdy) out_log.push_back(fu_data_o);
    @(posedge clk_i);
    if (v && !e_ready) m_stall++;
    if (fl) begin
      q.delete();
    end else begin
      if (m_pop && !was_empty) void'(q.pop_front());
      if (m_push && !(m_pop && was_empty)) q.push_back(d);
      if (m_push) in_log.push_back(d);
    end
    if (q.size() > m_hwm) m_hwm = q.size();
    @(negedge clk_i);
  endtask

  fu_data_t d1, d2, d3, d5, pend;
  bit       have;
  int       id;
  int       in0, out0, guard;

  initial begin
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    lsu_valid_i = 1'b0;
    lsu_ready_i = 1'b0;
    fu_data_i   = '0;
    #12;
    chk("rst.occ",   256'(occupancy_o), 256'(0));
    chk("rst.valid", 256'(lsu_valid_o), 256'(0));
    chk("rst.data",  256'(fu_data_o),   256'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // empty, LSU ready: zero-latency bypass, nothing stored
    d3 = mk(3);
    d3.fu = LOAD;
    cyc(1'b1, d3, 1'b1, 1'b0, "bypass");
    cyc(1'b0, '0, 1'b1, 1'b0, "bypass_idle");

    // fill under back-pressure, then drain with a blocked push while full
    d1 = mk(1);
    d2 = mk(2);
    d5 = mk(5);
    cyc(1'b1, d1, 1'b0, 1'b0, "fill1");
    cyc(1'b1, d2, 1'b0, 1'b0, "fill2");
    cyc(1'b1, d5, 1'b1, 1'b0, "full_pop");
    cyc(1'b1, d5, 1'b1, 1'b0, "push5");
    cyc(1'b0, '0, 1'b1, 1'b0, "drain5");
    cyc(1'b0, '0, 1'b1, 1'b0, "drained");
    chk("order.n", 256'(out_log.size()), 256'(4));
    if (out_log.size() == 4) begin
      chk("order.0", 256'(out_log[1].trans_id), 256'(1));
      chk("order.1", 256'(out_log[2].trans_id), 256'(2));
      chk("order.2", 256'(out_log[3].trans_id), 256'(5));
    end

    // flush with a full buffer and a push attempt
    cyc(1'b1, mk(6), 1'b0, 1'b0, "fl_fill1");
    cyc(1'b1, mk(7), 1'b0, 1'b0, "fl_fill2");
    out0 = out_log.size();
    cyc(1'b1, mk(4), 1'b1, 1'b1, "flush");
    cyc(1'b0, '0, 1'b1, 1'b0, "post_flush");
    chk("flush.nopop", 256'(out_log.size() - out0), 256'(0));

    // random push/pop with LSU stalls; issue holds its op until accepted
    in0  = in_log.size();
    out0 = out_log.size();
    have = 1'b0;
    id   = 0;
    guard = 0;
    while ((out_log.size() - out0) < 12 && guard < 400) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        pend = mk(id);
        id++;
        have = 1'b1;
      end
      cyc(have, have ? pend : '0, $urandom_range(0, 2) != 0, 1'b0, "rnd");
      if (m_push) have = 1'b0;
      guard++;
    end
    chk("rnd.progress", 256'(guard < 400), 256'(1));
    guard = 0;
    while ((have || q.size() != 0) && guard < 50) begin
      cyc(have, have ? pend : '0, 1'b1, 1'b0, "rnd_drain");
      if (m_push) have = 1'b0;
      guard++;
    end
    chk("rnd.count", 256'(out_log.size() - out0), 256'(in_log.size() - in0));
    if ((out_log.size() - out0) == (in_log.size() - in0)) begin
      for (int i = 0; i < in_log.size() - in0; i++) begin
        chk($sformatf("rnd.seq%0d", i), 256'(out_log[out0 + i]), 256'(in_log[in0 + i]));
      end
    end

    // asynchronous reset with one entry buffered
    cyc(1'b1, mk(2), 1'b0, 1'b0, "pre_rst");
    lsu_valid_i = 1'b0;
    lsu_ready_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst.occ",   256'(occupancy_o), 256'(0));
    chk("arst.valid", 256'(lsu_valid_o), 256'(0));
    chk("arst.ready", 256'(lsu_ready_o), 256'(1));
`ifdef LSU_BUF_STATS_EN
    chk("arst.stall", 256'(stall_cnt_o), 256'(0));
    chk("arst.hwm",   256'(hwm_o),       256'(0));
`endif
    q.delete();
    m_stall = 0;
    m_hwm   = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
